// File: rtl/ula_arbiter_if.sv
// Bundle between two requesters, the arbiter and a shared combinational ALU.
// The arbiter is on the slave side; the requesters and the ALU together are on the master side.
interface ula_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_In1;
  logic [WIDTH-1:0] req0_In2;
  logic [3:0]       req0_OP;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_In1;
  logic [WIDTH-1:0] req1_In2;
  logic [3:0]       req1_OP;

  logic             resp0_valid;
  logic             resp0_ready;
  logic [WIDTH-1:0] resp0_result;
  logic             resp0_Zero_flag;

  logic             resp1_valid;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp1_result;
  logic             resp1_Zero_flag;

  logic [WIDTH-1:0] ula_In1;
  logic [WIDTH-1:0] ula_In2;
  logic [3:0]       ula_OP;
  logic [WIDTH-1:0] ula_result;
  logic             ula_Zero_flag;

  logic             busy;

  modport slave (
    input  req0_valid, req0_In1, req0_In2, req0_OP,
    input  req1_valid, req1_In1, req1_In2, req1_OP,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_Zero_flag,
    output resp1_valid, resp1_result, resp1_Zero_flag,
    input  resp0_ready, resp1_ready,
    output ula_In1, ula_In2, ula_OP,
    input  ula_result, ula_Zero_flag,
    output busy
  );

  modport master (
    output req0_valid, req0_In1, req0_In2, req0_OP,
    output req1_valid, req1_In1, req1_In2, req1_OP,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_Zero_flag,
    input  resp1_valid, resp1_result, resp1_Zero_flag,
    output resp0_ready, resp1_ready,
    input  ula_In1, ula_In2, ula_OP,
    output ula_result, ula_Zero_flag,
    input  busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: accept (IDLE) -> capture (EXEC) -> hold result (RESP).
module ula_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  ula_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] in1_q, in1_d;
  logic [WIDTH-1:0] in2_q, in2_d;
  logic [3:0]       op_q, op_d;

  logic [WIDTH-1:0] result_q [2];
  logic             zero_q   [2];

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       resp_ready;
  logic [1:0]       resp_valid;
  logic [WIDTH-1:0] req_in1 [2];
  logic [WIDTH-1:0] req_in2 [2];
  logic [3:0]       req_op  [2];

  logic             any_valid;
  logic             grant;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};
  assign req_in1[0] = bus.req0_In1;
  assign req_in1[1] = bus.req1_In1;
  assign req_in2[0] = bus.req0_In2;
  assign req_in2[1] = bus.req1_In2;
  assign req_op[0]  = bus.req0_OP;
  assign req_op[1]  = bus.req1_OP;

  // On a tie the requester that was not granted last time wins.
  assign any_valid = |req_valid;
  assign grant     = (&req_valid) ? ~last_q : req_valid[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi]  = (state_q == IDLE) && any_valid && (grant == 1'(gi));
      assign resp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          result_q[gi] <= '0;
          zero_q[gi]   <= 1'b0;
        end else if ((state_q == EXEC) && (owner_q == 1'(gi))) begin
          result_q[gi] <= bus.ula_result;
          zero_q[gi]   <= bus.ula_Zero_flag;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      in1_q   <= '0;
      in2_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    op_d    = op_q;
    case (state_q)
      IDLE: begin
        // Any valid request is accepted in the same cycle it is offered.
        if (any_valid) begin
          state_d = EXEC;
          owner_d = grant;
          last_d  = grant;
          in1_d   = req_in1[grant];
          in2_d   = req_in2[grant];
          op_d    = req_op[grant];
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (resp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready      = req_ready[0];
  assign bus.req1_ready      = req_ready[1];
  assign bus.resp0_valid     = resp_valid[0];
  assign bus.resp1_valid     = resp_valid[1];
  assign bus.resp0_result    = result_q[0];
  assign bus.resp1_result    = result_q[1];
  assign bus.resp0_Zero_flag = zero_q[0];
  assign bus.resp1_Zero_flag = zero_q[1];
  assign bus.ula_In1         = in1_q;
  assign bus.ula_In2         = in2_q;
  assign bus.ula_OP          = op_q;
  assign bus.busy            = (state_q != IDLE);

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed and randomized checks of ula_arbiter against a transaction-level model
// (who should win, what the ALU should return) with a reference ALU on the shared port.
module tb_ula_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ula_arbiter_if #(.WIDTH(W)) bus ();
  ula_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [3:0] op);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  assign bus.ula_result    = alu(bus.ula_In1, bus.ula_In2, bus.ula_OP);
  assign bus.ula_Zero_flag = (bus.ula_result == '0);

  int tests = 0;
  int fails = 0;

  // Pending requests as seen by the model, and who was served most recently.
  logic         mv [2] = '{1'b0, 1'b0};
  logic [W-1:0] ma [2] = '{'0, '0};
  logic [W-1:0] mb [2] = '{'0, '0};
  logic [3:0]   mo [2] = '{4'd0, 4'd0};
  int           last_served = 1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    bus.req0_valid = mv[0];
    bus.req0_In1   = ma[0];
    bus.req0_In2   = mb[0];
    bus.req0_OP    = mo[0];
    bus.req1_valid = mv[1];
    bus.req1_In1   = ma[1];
    bus.req1_In2   = mb[1];
    bus.req1_OP    = mo[1];
    #1;
  endtask

  task automatic new_op(input int n);
    ma[n] = $urandom;
    mb[n] = ($urandom_range(0, 3) == 0) ? ma[n] : W'($urandom);
    mo[n] = 4'($urandom_range(0, 15));
  endtask

  function automatic logic [1:0] rvalid();
    return {bus.resp1_valid, bus.resp0_valid};
  endfunction

  function automatic logic [1:0] rdy();
    return {bus.req1_ready, bus.req0_ready};
  endfunction

  function automatic logic [W-1:0] res_of(input int n);
    return (n == 1) ? bus.resp1_result : bus.resp0_result;
  endfunction

  function automatic logic zf_of(input int n);
    return (n == 1) ? bus.resp1_Zero_flag : bus.resp0_Zero_flag;
  endfunction

  // other_mode: 0 leave the other requester alone, 1 raise it after the handshake,
  // 2 raise it and withdraw it before the response completes.
  task automatic serve(input string tag, input int delay, input int other_mode, input bit keep);
    int           exp_n;
    int           o;
    int           waited;
    bit           raised;
    logic [W-1:0] ea, eb, er;
    logic [3:0]   eo;
    logic [1:0]   onehot;
    exp_n  = (mv[0] && mv[1]) ? ((last_served == 0) ? 1 : 0) : (mv[1] ? 1 : 0);
    o      = 1 - exp_n;
    onehot = (exp_n == 1) ? 2'b10 : 2'b01;
    waited = 0;
    while (rdy() == 2'b00 && waited < 4) begin
      tick();
      waited++;
    end
    chk({tag, "/grant_seen"}, W'(waited < 4), W'(1));
    chk({tag, "/grant"}, W'(rdy()), W'(onehot));
    ea = ma[exp_n];
    eb = mb[exp_n];
    eo = mo[exp_n];
    er = alu(ea, eb, eo);
    tick();
    if (keep) new_op(exp_n);
    else mv[exp_n] = 1'b0;
    raised = 1'b0;
    if (other_mode != 0 && !mv[o]) begin
      mv[o] = 1'b1;
      new_op(o);
      raised = 1'b1;
    end
    apply();
    chk({tag, "/exec_busy"}, W'(bus.busy), W'(1));
    chk({tag, "/exec_ready"}, W'(rdy()), W'(0));
    chk({tag, "/exec_rvalid"}, W'(rvalid()), W'(0));
    chk({tag, "/ula_In1"}, bus.ula_In1, ea);
    chk({tag, "/ula_In2"}, bus.ula_In2, eb);
    chk({tag, "/ula_OP"}, W'(bus.ula_OP), W'(eo));
    tick();
    chk({tag, "/rvalid"}, W'(rvalid()), W'(onehot));
    chk({tag, "/result"}, res_of(exp_n), er);
    chk({tag, "/zero"}, W'(zf_of(exp_n)), W'(er == '0));
    for (int i = 0; i < delay; i++) begin
      if (exp_n == 1) bus.resp0_ready = 1'b1;
      else bus.resp1_ready = 1'b1;
      tick();
      chk({tag, "/hold_rvalid"}, W'(rvalid()), W'(onehot));
      chk({tag, "/hold_result"}, res_of(exp_n), er);
      chk({tag, "/hold_busy"}, W'(bus.busy), W'(1));
      chk({tag, "/hold_ready"}, W'(rdy()), W'(0));
    end
    if (other_mode == 2 && raised) mv[o] = 1'b0;
    bus.resp0_ready = (exp_n == 0);
    bus.resp1_ready = (exp_n == 1);
    apply();
    tick();
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    chk({tag, "/done_busy"}, W'(bus.busy), W'(0));
    chk({tag, "/done_rvalid"}, W'(rvalid()), W'(0));
    chk({tag, "/retained"}, res_of(exp_n), er);
    $display("[TB] %s: requester %0d op=%0h a=%0h b=%0h -> %0h", tag, exp_n, eo, ea, eb, er);
    last_served = exp_n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.resp0_ready = 1'b0;
    bus.resp1_ready = 1'b0;
    apply();
    tick();
    tick();
    chk("reset/busy", W'(bus.busy), W'(0));
    chk("reset/rvalid", W'(rvalid()), W'(0));
    chk("reset/ready", W'(rdy()), W'(0));
    chk("reset/ula_In1", bus.ula_In1, '0);
    chk("reset/ula_OP", W'(bus.ula_OP), W'(0));
    chk("reset/res0", bus.resp0_result, '0);
    chk("reset/zf1", W'(bus.resp1_Zero_flag), W'(0));
    rst_n = 1'b1;
    tick();

    // Tie from reset: req0 must win first.
    mv[0] = 1'b1; ma[0] = 7;     mb[0] = 7;     mo[0] = 4'b0110;
    mv[1] = 1'b1; ma[1] = 'h0F;  mb[1] = 'hF0;  mo[1] = 4'b0001;
    apply();
    serve("tie_first", 0, 0, 1'b0);
    serve("tie_second", 0, 0, 1'b0);
    chk("tie/res0", bus.resp0_result, '0);
    chk("tie/zf0", W'(bus.resp0_Zero_flag), W'(1));
    chk("tie/res1", bus.resp1_result, W'('hFF));

    mv[0] = 1'b1; ma[0] = 5; mb[0] = 3; mo[0] = 4'b0010;
    apply();
    serve("single", 0, 0, 1'b0);
    chk("single/res0", bus.resp0_result, W'(8));

    mv[0] = 1'b1; new_op(0);
    mv[1] = 1'b1; new_op(1);
    apply();
    for (int i = 0; i < 6; i++) serve("fair", 0, 0, 1'b1);
    mv[0] = 1'b0; mv[1] = 1'b0;
    apply();
    tick();

    mv[1] = 1'b1; new_op(1);
    apply();
    serve("backpressure", 5, 1, 1'b0);
    serve("held_off", 0, 0, 1'b0);

    mv[0] = 1'b1; new_op(0);
    apply();
    serve("withdraw", 1, 2, 1'b0);
    mv[0] = 1'b1; new_op(0);
    apply();
    serve("after_withdraw", 0, 0, 1'b0);

    // Reset while the accepted operation is in EXEC.
    mv[0] = 1'b1; new_op(0);
    ma[0] = 'h1234;
    apply();
    tick();
    mv[0] = 1'b0;
    apply();
    rst_n = 1'b0;
    #1;
    chk("midrst/busy", W'(bus.busy), W'(0));
    chk("midrst/rvalid", W'(rvalid()), W'(0));
    chk("midrst/ula_In1", bus.ula_In1, '0);
    chk("midrst/ula_In2", bus.ula_In2, '0);
    chk("midrst/ula_OP", W'(bus.ula_OP), W'(0));
    tick();
    rst_n = 1'b1;
    last_served = 1;
    tick();
    chk("midrst/idle_rvalid", W'(rvalid()), W'(0));
    mv[1] = 1'b1; ma[1] = 'hF0F0; mb[1] = 'hFF00; mo[1] = 4'b0000;
    apply();
    serve("after_reset", 0, 0, 1'b0);
    chk("after_reset/res1", bus.resp1_result, W'('hF000));

    for (int k = 0; k < 40; k++) begin
      for (int n = 0; n < 2; n++) begin
        if (!mv[n] && $urandom_range(0, 1) == 1) begin
          mv[n] = 1'b1;
          new_op(n);
        end
      end
      if (!mv[0] && !mv[1]) begin
        mv[k % 2] = 1'b1;
        new_op(k % 2);
      end
      apply();
      serve("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
            1'($urandom_range(0, 1)));
    end
    mv[0] = 1'b0; mv[1] = 1'b0;
    apply();
    tick();
    chk("end/busy", W'(bus.busy), W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
